// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer draining a first-word-fall-through TX FIFO.
// Frames are start, 8 data bits LSB first, optional parity, one stop bit.
module uart_tx_fifo_drain #(
  parameter int unsigned clk_per_bit = 868,
  parameter string       parity_mode = "none"
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fifo_ren,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic        par_en   = (parity_mode != "none");
  localparam logic        par_odd  = (parity_mode == "odd");
  localparam logic [15:0] baud_max = 16'(clk_per_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        pop;

  always_comb begin
    bit_end = (baud_q == baud_max);
    pop     = fifo_empty_n &&
              ((state_q == S_IDLE) ||
               ((state_q == S_STOP) && bit_end));
    state_d = state_q;
    baud_d  = 16'd0;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE && !bit_end) begin
      baud_d = baud_q + 16'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          tx_d    = shreg_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (par_en) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    // A pop overrides everything: latch the head and start a new frame.
    if (pop) begin
      shreg_d = fifo_dout;
      par_d   = (^fifo_dout) ^ par_odd;
      tx_d    = 1'b0;
      state_d = S_START;
      baud_d  = 16'd0;
      bit_d   = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign fifo_ren = pop && !rst;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != S_IDLE) && !rst;
  assign tx_done  = (state_q == S_STOP) && bit_end && !rst;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: four instances (none/even/odd at 4 clk/bit,
// none at 2 clk/bit) checked cycle by cycle against a frame-level model.
module tb_uart_tx_fifo_drain;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ren, tx, busy, done, empty_n;
  logic [7:0]   dout;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned CPB = (g == 3) ? 2 : 4;
    localparam string PM = (g == 1) ? "even" :
                           (g == 2) ? "odd" : "none";
    uart_tx_fifo_drain #(
      .clk_per_bit(CPB),
      .parity_mode(PM)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_ren    (ren[g]),
      .fifo_dout   (dout),
      .fifo_empty_n(empty_n[g]),
      .tx          (tx[g]),
      .tx_busy     (busy[g]),
      .tx_done     (done[g])
    );
  end

  int         sel;
  logic [7:0] fq[$];
  logic [2:0] exp_q[$];
  int         checks, errors, cyc;
  int         pops_dut, pops_ref;

  function automatic int cpb_of(int k);
    return (k == 3) ? 2 : 4;
  endfunction

  // 0 = none, 1 = even, 2 = odd
  function automatic int par_of(int k);
    return (k == 1) ? 1 : (k == 2) ? 2 : 0;
  endfunction

  task automatic drive();
    empty_n = '0;
    if (fq.size() != 0) begin
      empty_n[sel] = 1'b1;
      dout = fq[0];
    end else begin
      dout = 8'($urandom);
    end
  endtask

  // Expected per-cycle {tx, busy, done} for one whole frame.
  task automatic push_frame(input logic [7:0] b);
    int   nb;
    int   cpb;
    logic bv;
    nb  = (par_of(sel) != 0) ? 11 : 10;
    cpb = cpb_of(sel);
    for (int i = 0; i < nb; i++) begin
      if (i == 0) bv = 1'b0;
      else if (i <= 8) bv = b[i-1];
      else if (i == 9 && nb == 11)
        bv = (($countones(b) % 2) == 1) ^ (par_of(sel) == 2);
      else bv = 1'b1;
      for (int c = 0; c < cpb; c++)
        exp_q.push_back({bv, 1'b1, (i == nb-1 && c == cpb-1)});
    end
  endtask

  // Advance one cycle; o/e = {tx, busy, done, ren} observed/expected.
  task automatic tick(output logic [3:0] o, output logic [3:0] e);
    logic [2:0] cur;
    logic       idle;
    #1;
    o    = {tx[sel], busy[sel], done[sel], ren[sel]};
    idle = (exp_q.size() == 0);
    cur  = idle ? 3'b100 : exp_q.pop_front();
    e    = {cur, 1'b0};
    if (rst) begin
      e = {cur[2], 3'b000};
      exp_q.delete();
    end else if (fq.size() != 0 && (idle || cur[0])) begin
      e[0] = 1'b1;
      push_frame(fq[0]);
      pops_ref++;
    end
    if (o[0]) pops_dut++;
    cyc++;
    @(posedge clk);
    #1;
    if (o[0] && fq.size() != 0) fq.delete(0);
    drive();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] o, e;
    sel = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(o, e);
      checks++;
      if (o !== e || busy !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b busy=%b exp=%b", cyc, o, busy, e);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] o, e;
    logic [9:0] seen, want;
    int         dcnt, bcnt, dat;
    sel = 0; pops_dut = 0; pops_ref = 0;
    dcnt = 0; bcnt = 0; dat = -1; seen = '0;
    want = 10'b1101001010;
    fq.push_back(8'hA5);
    drive();
    for (int i = 0; i < 46; i++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      dcnt += int'(o[1]);
      bcnt += int'(o[2]);
      if (o[1]) dat = i;
      if (i >= 1 && i <= 40 && ((i - 1) % 4) == 2) seen[(i-1)/4] = o[3];
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL single_bits got=%b exp=%b", seen, want);
    end
    checks++;
    if (dcnt != 1 || dat != 40 || bcnt != 40 || pops_dut != 1) begin
      errors++;
      $display("FAIL single_cnt done=%0d@%0d busy=%0d pops=%0d exp 1@40 40 1",
               dcnt, dat, bcnt, pops_dut);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] o, e;
    int         dcnt, bcnt;
    sel = 0; pops_dut = 0; pops_ref = 0; dcnt = 0; bcnt = 0;
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    drive();
    for (int i = 0; i < 86; i++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, o, e);
      end
      dcnt += int'(o[1]);
      bcnt += int'(o[2]);
    end
    checks++;
    if (pops_dut != 2 || dcnt != 2 || bcnt != 80) begin
      errors++;
      $display("FAIL b2b_cnt pops=%0d done=%0d busy=%0d exp 2 2 80",
               pops_dut, dcnt, bcnt);
    end
  endtask

  task automatic test_parity();
    logic [3:0] o, e;
    int         bcnt;
    logic       pbit;
    for (int k = 1; k <= 2; k++) begin
      sel = k; pops_dut = 0; pops_ref = 0; bcnt = 0; pbit = 1'bx;
      fq.push_back(8'h07);
      drive();
      for (int i = 0; i < 50; i++) begin
        tick(o, e);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL parity%0d cyc=%0d got=%b exp=%b", k, cyc, o, e);
        end
        bcnt += int'(o[2]);
        if (i == 39) pbit = o[3];
      end
      checks++;
      if (bcnt != 44 || pops_dut != 1 || pbit !== (k == 1)) begin
        errors++;
        $display("FAIL parity%0d_cnt busy=%0d pops=%0d pbit=%b exp 44 1 %0d",
                 k, bcnt, pops_dut, pbit, (k == 1));
      end
    end
  endtask

  task automatic test_empty();
    logic [3:0] o, e;
    sel = 0; pops_dut = 0; pops_ref = 0;
    for (int i = 0; i < 100; i++) begin
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL empty cyc=%0d got=%b exp=%b", cyc, o, e);
      end
    end
    checks++;
    if (pops_dut != 0) begin
      errors++;
      $display("FAIL empty_pops got=%0d exp=0", pops_dut);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] o, e;
    sel = 0; pops_dut = 0; pops_ref = 0;
    for (int i = 0; i < 3; i++) fq.push_back(8'($urandom));
    drive();
    for (int i = 0; i < 110; i++) begin
      rst = (i == 18);
      tick(o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rst_mid cyc=%0d got=%b exp=%b", cyc, o, e);
      end
    end
    rst = 1'b0;
    checks++;
    if (pops_dut != 3 || fq.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_pops got=%0d left=%0d exp 3 0",
               pops_dut, fq.size());
    end
  endtask

  task automatic test_random();
    logic [3:0] o, e;
    for (int k = 0; k < N; k++) begin
      sel = k; pops_dut = 0; pops_ref = 0;
      drive();
      for (int i = 0; i < 650; i++) begin
        if (i < 400 && fq.size() < 4 && $urandom_range(7) == 0) begin
          fq.push_back(8'($urandom));
          drive();
        end
        tick(o, e);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL random%0d cyc=%0d got=%b exp=%b", k, cyc, o, e);
        end
      end
      checks++;
      if (pops_dut != pops_ref || fq.size() != 0) begin
        errors++;
        $display("FAIL random%0d_pops got=%0d exp=%0d left=%0d",
                 k, pops_dut, pops_ref, fq.size());
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    pops_dut = 0; pops_ref = 0;
    sel = 0;
    rst = 1'b1;
    empty_n = '0;
    dout = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_empty();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
